// File: rtl/cci_mpf_prim_lfsr_check.sv
// Receive-side checker for the MPF LFSR pattern generators: self-synchronizes to the
// incoming sequence, then flags mismatches, counts errors/checked beats and detects loss of lock.
module cci_mpf_prim_lfsr_check #(
  parameter int WIDTH          = 32,
  parameter int LOCK_COUNT     = 8,
  parameter int LOSS_THRESHOLD = 4,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   locked,
  output logic                   err,
  output logic                   lock_lost,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [COUNT_WIDTH-1:0] chk_count
);

  generate
    if (!(WIDTH == 12 || WIDTH == 32)) begin : g_bad_width
      $error("cci_mpf_prim_lfsr_check: WIDTH must be 12 or 32");
    end
    if (LOCK_COUNT < 1 || LOSS_THRESHOLD < 1) begin : g_bad_thresh
      $error("cci_mpf_prim_lfsr_check: LOCK_COUNT and LOSS_THRESHOLD must be >= 1");
    end
  endgenerate

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(LOSS_THRESHOLD + 1);

  // Feedback taps: bits that receive v[0] XORed on top of the plain right shift.
  localparam logic [WIDTH-1:0] TAPS = (WIDTH == 12) ? WIDTH'(12'h029) : WIDTH'(32'h0000_0057);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]} ^ (v[0] ? TAPS : '0);
  endfunction

  state_t           state, state_n;
  logic [WIDTH-1:0] expected, expected_n;
  logic [MW-1:0]    match_cnt, match_n;
  logic [SW-1:0]    miss_cnt, miss_n;
  logic             err_n, lost_n, err_inc, chk_inc;
  logic             hit, nonzero;

  assign hit     = (in_data == expected);
  assign nonzero = |in_data;

  always_comb begin
    state_n    = state;
    expected_n = expected;
    match_n    = match_cnt;
    miss_n     = miss_cnt;
    err_n      = 1'b0;
    lost_n     = 1'b0;
    err_inc    = 1'b0;
    chk_inc    = 1'b0;
    if (in_valid) begin
      case (state)
        SEARCH: begin
          if (nonzero) begin
            expected_n = lfsr_next(in_data);
            match_n    = '0;
            state_n    = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            expected_n = lfsr_next(in_data);
            match_n    = match_cnt + MW'(1);
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else if (nonzero) begin
            expected_n = lfsr_next(in_data);
            match_n    = '0;
          end else begin
            state_n = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: once locked, the received data never reseeds the expectation.
          expected_n = lfsr_next(expected);
          chk_inc    = 1'b1;
          if (hit) begin
            miss_n = '0;
          end else begin
            err_n   = 1'b1;
            err_inc = 1'b1;
            miss_n  = miss_cnt + SW'(1);
            if (miss_cnt == SW'(LOSS_THRESHOLD - 1)) begin
              lost_n  = 1'b1;
              state_n = SEARCH;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SEARCH;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      expected  <= expected_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= (state_n == LOCKED);
      err       <= err_n;
      lock_lost <= lost_n;
    end
  end

  // Saturating counters; a clear coinciding with an increment loads one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count <= '0;
      chk_count <= '0;
    end else begin
      if (clear)
        err_count <= err_inc ? COUNT_WIDTH'(1) : '0;
      else if (err_inc && !(&err_count))
        err_count <= err_count + COUNT_WIDTH'(1);

      if (clear)
        chk_count <= chk_inc ? COUNT_WIDTH'(1) : '0;
      else if (chk_inc && !(&chk_count))
        chk_count <= chk_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cci_mpf_prim_lfsr_check.sv
// Bench for cci_mpf_prim_lfsr_check: directed 12- and 32-bit streams, compared every cycle
// against a behavioural model of the 32-bit checker plus hand-computed literal expectations.
module tb_cci_mpf_prim_lfsr_check;

  localparam int CW    = 10;
  localparam int LOCKN = 4;
  localparam int LOSSN = 4;
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, clear, v32, v12;
  logic [31:0]   d32;
  logic [11:0]   d12;
  logic          locked32, err32, lost32, locked12, err12, lost12;
  logic [CW-1:0] ec32, cc32, ec12, cc12;

  int n_checks = 0;
  int n_errors = 0;

  cci_mpf_prim_lfsr_check #(.WIDTH(32), .LOCK_COUNT(LOCKN), .LOSS_THRESHOLD(LOSSN), .COUNT_WIDTH(CW)) u32 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(v32), .in_data(d32),
    .locked(locked32), .err(err32), .lock_lost(lost32), .err_count(ec32), .chk_count(cc32)
  );

  cci_mpf_prim_lfsr_check #(.WIDTH(12), .LOCK_COUNT(LOCKN), .LOSS_THRESHOLD(LOSSN), .COUNT_WIDTH(CW)) u12 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(v12), .in_data(d12),
    .locked(locked12), .err(err12), .lock_lost(lost12), .err_count(ec12), .chk_count(cc12)
  );

  function automatic logic [31:0] step32(input logic [31:0] v);
    logic [31:0] n;
    n[31] = v[0];
    for (int i = 0; i < 31; i++) n[i] = v[i+1];
    n[6] = v[7] ^ v[0];
    n[4] = v[5] ^ v[0];
    n[2] = v[3] ^ v[0];
    n[1] = v[2] ^ v[0];
    n[0] = v[1] ^ v[0];
    return n;
  endfunction

  function automatic logic [11:0] step12(input logic [11:0] v);
    logic [11:0] n;
    n[11] = v[0];
    for (int i = 0; i < 11; i++) n[i] = v[i+1];
    n[5] = v[6] ^ v[0];
    n[3] = v[4] ^ v[0];
    n[0] = v[1] ^ v[0];
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model of the 32-bit checker, advanced at every clock edge.
  bit          m_ready = 0, m_lock = 0, m_seeded = 0, m_err = 0, m_lost = 0;
  logic [31:0] m_exp = '0;
  int          m_run = 0, m_miss = 0;
  longint      m_ec = 0, m_cc = 0;

  initial begin
    bit inc_e, inc_c;
    forever begin
      @(posedge clk);
      inc_e = 0;
      inc_c = 0;
      if (!reset_n) begin
        m_ready = 1; m_lock = 0; m_seeded = 0; m_err = 0; m_lost = 0;
        m_exp = '0; m_run = 0; m_miss = 0; m_ec = 0; m_cc = 0;
      end else if (m_ready) begin
        m_err  = 0;
        m_lost = 0;
        if (v32) begin
          if (m_lock) begin
            inc_c = 1;
            if (d32 == m_exp) m_miss = 0;
            else begin
              m_err = 1; inc_e = 1; m_miss++;
              if (m_miss == LOSSN) begin m_lost = 1; m_lock = 0; m_seeded = 0; end
            end
            m_exp = step32(m_exp);
          end else if (m_seeded && d32 == m_exp) begin
            m_exp = step32(d32);
            m_run++;
            if (m_run == LOCKN) begin m_lock = 1; m_miss = 0; end
          end else if (d32 != 0) begin
            m_exp = step32(d32); m_run = 0; m_seeded = 1;
          end else begin
            m_seeded = 0;
          end
        end
        m_ec = clear ? longint'(inc_e) : ((inc_e && m_ec < CMAX) ? m_ec + 1 : m_ec);
        m_cc = clear ? longint'(inc_c) : ((inc_c && m_cc < CMAX) ? m_cc + 1 : m_cc);
      end
      #1;
      if (m_ready) begin
        checkOutput("model locked", locked32, m_lock);
        checkOutput("model err", err32, m_err);
        checkOutput("model lock_lost", lost32, m_lost);
        checkOutput("model err_count", ec32, m_ec);
        checkOutput("model chk_count", cc32, m_cc);
        checkOutput("u12 err quiet", err12, 0);
      end
    end
  end

  task automatic applyStimulus(input bit valid, input logic [31:0] data, input bit clr);
    v32   = valid;
    d32   = data;
    clear = clr;
    @(negedge clk);
    v32   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic apply12(input logic [11:0] data);
    v12 = 1'b1;
    d12 = data;
    @(negedge clk);
    v12 = 1'b0;
  endtask

  logic [31:0] g;
  logic [11:0] g12;

  task automatic sendGood();
    applyStimulus(1'b1, g, 1'b0);
    g = step32(g);
  endtask

  task automatic sendBad(input bit clr);
    applyStimulus(1'b1, g ^ 32'h1, clr);
    g = step32(g);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    reset_n = 1'b0; clear = 1'b0; v32 = 1'b0; v12 = 1'b0; d32 = '0; d12 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset locked", locked32, 0);
    checkOutput("reset err", err32, 0);
    checkOutput("reset lock_lost", lost32, 0);
    checkOutput("reset err_count", ec32, 0);
    checkOutput("reset chk_count", cc32, 0);
    checkOutput("reset u12 locked", locked12, 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] 12-bit lock from 0xA6B");
    apply12(12'hA6B);
    apply12(12'hD1C);
    g12 = step12(12'hD1C);
    apply12(g12); g12 = step12(g12);
    apply12(g12); g12 = step12(g12);
    checkOutput("u12 locked after 4 beats", locked12, 0);
    apply12(g12);
    checkOutput("u12 locked after 5 beats", locked12, 1);
    checkOutput("u12 err_count", ec12, 0);

    $display("[TB] 32-bit lock and single-bit error");
    applyStimulus(1'b1, 32'h0000_0001, 1'b0);
    applyStimulus(1'b1, 32'h8000_0057, 1'b0);
    g = step32(32'h8000_0057);
    sendGood(); sendGood();
    checkOutput("u32 locked after 4 beats", locked32, 0);
    sendGood();
    checkOutput("u32 locked after 5 beats", locked32, 1);
    repeat (3) sendGood();
    sendBad(1'b0);
    checkOutput("bit0 flip err", err32, 1);
    checkOutput("bit0 flip err_count", ec32, 1);
    sendGood();
    checkOutput("flywheel err clear", err32, 0);
    checkOutput("flywheel locked", locked32, 1);
    repeat (2) sendGood();
    checkOutput("flywheel err_count", ec32, 1);

    $display("[TB] loss of lock and relock");
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("clear err_count", ec32, 0);
    checkOutput("clear chk_count", cc32, 0);
    for (int k = 0; k < LOSSN; k++) begin
      sendBad(1'b0);
      checkOutput("burst err", err32, 1);
      checkOutput("burst lock_lost", lost32, (k == LOSSN - 1));
    end
    checkOutput("lost locked", locked32, 0);
    checkOutput("lost err_count", ec32, 4);
    checkOutput("lost chk_count", cc32, 4);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("lock_lost one cycle", lost32, 0);
    repeat (4) sendGood();
    checkOutput("relock after 4", locked32, 0);
    sendGood();
    checkOutput("relock after 5", locked32, 1);

    $display("[TB] zeros ignored in SEARCH");
    reset_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    reset_n = 1'b1;
    repeat (10) applyStimulus(1'b1, '0, 1'b0);
    checkOutput("zeros keep unlocked", locked32, 0);
    repeat (4) sendGood();
    checkOutput("zeros then seed after 4", locked32, 0);
    sendGood();
    checkOutput("zeros then seed after 5", locked32, 1);

    $display("[TB] 1000 words with random gaps");
    reset_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    reset_n = 1'b1;
    sent = 0;
    while (sent < 1000) begin
      if ($urandom_range(0, 1) == 1) begin
        sendGood();
        sent++;
      end else begin
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0);
      end
    end
    checkOutput("gaps locked", locked32, 1);
    checkOutput("gaps err_count", ec32, 0);
    checkOutput("gaps chk_count", cc32, 995);

    $display("[TB] clear with error, then saturation");
    sendBad(1'b1);
    checkOutput("clear+err err_count", ec32, 1);
    checkOutput("clear+chk chk_count", cc32, 1);
    sendGood();
    for (int r = 0; r < 341; r++) begin
      repeat (3) sendBad(1'b0);
      sendGood();
    end
    checkOutput("saturated err_count", ec32, CMAX);
    sendBad(1'b0);
    checkOutput("saturated err pulse", err32, 1);
    checkOutput("saturated err_count hold", ec32, CMAX);
    checkOutput("saturated chk_count", cc32, CMAX);
    checkOutput("saturated still locked", locked32, 1);

    $display("[TB] reset while locked");
    reset_n = 1'b0;
    applyStimulus(1'b1, g ^ 32'h1, 1'b1);
    checkOutput("mid reset locked", locked32, 0);
    checkOutput("mid reset err", err32, 0);
    checkOutput("mid reset lock_lost", lost32, 0);
    checkOutput("mid reset err_count", ec32, 0);
    checkOutput("mid reset chk_count", cc32, 0);
    reset_n = 1'b1;
    repeat (2) applyStimulus(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
